// File: rtl/core_data_demux_pkg.sv
// Shared types and default address map for the core data demux.
package core_data_demux_pkg;

  typedef enum logic [1:0] {
    DEST_TCDM   = 2'd0,
    DEST_PERIPH = 2'd1,
    DEST_ERR    = 2'd2
  } dest_e;

  localparam logic [31:0] TCDM_START_DEF   = 32'h1000_0000;
  localparam logic [31:0] TCDM_SIZE_DEF    = 32'h0002_0000;
  localparam logic [31:0] PERIPH_START_DEF = 32'h1020_0000;
  localparam logic [31:0] PERIPH_SIZE_DEF  = 32'h0000_4000;
  localparam logic [31:0] ERR_RDATA_DEF    = 32'hBADA_CCE5;

endpackage

// File: rtl/core_data_demux_addr_dec.sv
// Address window decoder: TCDM first, then peripherals, else error.
module core_data_demux_addr_dec
  import core_data_demux_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] TCDM_START   = TCDM_START_DEF,
  parameter logic [ADDR_WIDTH-1:0] TCDM_SIZE    = TCDM_SIZE_DEF,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_START = PERIPH_START_DEF,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_SIZE  = PERIPH_SIZE_DEF
) (
  input  logic [ADDR_WIDTH-1:0] add,
  output dest_e                 dest
);

  // One extra bit so a window touching the top of memory cannot wrap
  localparam logic [ADDR_WIDTH:0] T_LO = {1'b0, TCDM_START};
  localparam logic [ADDR_WIDTH:0] T_HI = T_LO + {1'b0, TCDM_SIZE};
  localparam logic [ADDR_WIDTH:0] P_LO = {1'b0, PERIPH_START};
  localparam logic [ADDR_WIDTH:0] P_HI = P_LO + {1'b0, PERIPH_SIZE};

  logic [ADDR_WIDTH:0] a;
  logic                in_t;
  logic                in_p;

  assign a    = {1'b0, add};
  assign in_t = (a >= T_LO) && (a < T_HI);
  assign in_p = (a >= P_LO) && (a < P_HI);

  always_comb begin
    dest = DEST_ERR;
    if (in_t)      dest = DEST_TCDM;
    else if (in_p) dest = DEST_PERIPH;
  end

endmodule

// File: rtl/core_data_demux.sv
// Splits one core data port into TCDM, peripheral and error paths,
// keeping responses in order by stalling on a change of destination.
module core_data_demux
  import core_data_demux_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           BE_WIDTH        = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] TCDM_START      = TCDM_START_DEF,
  parameter logic [ADDR_WIDTH-1:0] TCDM_SIZE       = TCDM_SIZE_DEF,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_START    = PERIPH_START_DEF,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_SIZE     = PERIPH_SIZE_DEF,
  parameter int unsigned           MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = ERR_RDATA_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_req_i,
  input  logic [ADDR_WIDTH-1:0] core_add_i,
  input  logic                  core_wen_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic [BE_WIDTH-1:0]   core_be_i,
  output logic                  core_gnt_o,
  output logic                  core_r_valid_o,
  output logic [DATA_WIDTH-1:0] core_r_rdata_o,
  output logic                  core_r_opc_o,
  output logic [ADDR_WIDTH-1:0] out_add_o,
  output logic                  out_wen_o,
  output logic [DATA_WIDTH-1:0] out_wdata_o,
  output logic [BE_WIDTH-1:0]   out_be_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_rdata_i,
  output logic                  periph_req_o,
  input  logic                  periph_gnt_i,
  input  logic                  periph_r_valid_i,
  input  logic [DATA_WIDTH-1:0] periph_r_rdata_i,
  input  logic                  periph_r_opc_i
);

  localparam int unsigned   CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt;
  dest_e         last_dest;
  logic          err_pend;
  dest_e         dest;
  logic          busy;
  logic          allow;
  logic          accept;
  logic          ret;
  logic          stray;

  core_data_demux_addr_dec #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .TCDM_START   (TCDM_START),
    .TCDM_SIZE    (TCDM_SIZE),
    .PERIPH_START (PERIPH_START),
    .PERIPH_SIZE  (PERIPH_SIZE)
  ) u_dec (
    .add  (core_add_i),
    .dest (dest)
  );

  assign busy  = (cnt != '0);
  assign allow = core_req_i & ~rst_i
               & (~busy | (dest == last_dest))
               & (cnt < CMAX);

  assign tcdm_req_o   = allow & (dest == DEST_TCDM);
  assign periph_req_o = allow & (dest == DEST_PERIPH);
  assign core_gnt_o   = (tcdm_req_o & tcdm_gnt_i)
                      | (periph_req_o & periph_gnt_i)
                      | (allow & (dest == DEST_ERR));
  assign accept       = core_gnt_o;

  assign out_add_o   = core_add_i;
  assign out_wen_o   = core_wen_i;
  assign out_wdata_o = core_wdata_i;
  assign out_be_o    = core_be_i;

  always_comb begin
    core_r_valid_o = 1'b0;
    core_r_rdata_o = '0;
    core_r_opc_o   = 1'b0;
    unique case (last_dest)
      DEST_TCDM: begin
        if (tcdm_r_valid_i && busy) begin
          core_r_valid_o = 1'b1;
          core_r_rdata_o = tcdm_r_rdata_i;
        end
      end
      DEST_PERIPH: begin
        if (periph_r_valid_i && busy) begin
          core_r_valid_o = 1'b1;
          core_r_rdata_o = periph_r_rdata_i;
          core_r_opc_o   = periph_r_opc_i;
        end
      end
      DEST_ERR: begin
        if (err_pend) begin
          core_r_valid_o = 1'b1;
          core_r_rdata_o = ERR_RDATA;
          core_r_opc_o   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ret = core_r_valid_o & busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      last_dest <= DEST_TCDM;
      err_pend  <= 1'b0;
    end else begin
      if (accept) last_dest <= dest;
      cnt      <= cnt + CW'(accept) - CW'(ret);
      err_pend <= accept & (dest == DEST_ERR);
    end
  end

  // Responses from the unselected target or with nothing in flight are lost
  assign stray = (tcdm_r_valid_i
                  & ((last_dest != DEST_TCDM) | ~busy))
               | (periph_r_valid_i
                  & ((last_dest != DEST_PERIPH) | ~busy));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!stray)
        else $warning("core_data_demux: stray response dropped");
    end
  end

endmodule

// File: tb/tb_core_data_demux.sv
// Directed bench for core_data_demux: routing, ordering, error path, reset.
module tb_core_data_demux;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic [31:0] o_add;
  logic        o_wen;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic        tcdm_r_valid;
  logic [31:0] tcdm_r_rdata;
  logic        periph_req;
  logic        periph_gnt;
  logic        periph_r_valid;
  logic [31:0] periph_r_rdata;
  logic        periph_r_opc;

  int total = 0;
  int bad   = 0;

  core_data_demux dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .core_req_i       (req),
    .core_add_i       (add),
    .core_wen_i       (wen),
    .core_wdata_i     (wdata),
    .core_be_i        (be),
    .core_gnt_o       (gnt),
    .core_r_valid_o   (r_valid),
    .core_r_rdata_o   (r_rdata),
    .core_r_opc_o     (r_opc),
    .out_add_o        (o_add),
    .out_wen_o        (o_wen),
    .out_wdata_o      (o_wdata),
    .out_be_o         (o_be),
    .tcdm_req_o       (tcdm_req),
    .tcdm_gnt_i       (tcdm_gnt),
    .tcdm_r_valid_i   (tcdm_r_valid),
    .tcdm_r_rdata_i   (tcdm_r_rdata),
    .periph_req_o     (periph_req),
    .periph_gnt_i     (periph_gnt),
    .periph_r_valid_i (periph_r_valid),
    .periph_r_rdata_i (periph_r_rdata),
    .periph_r_opc_i   (periph_r_opc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; add = '0; wen = 1'b1;
    wdata = '0; be = 4'hF;
    tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0; tcdm_r_rdata = '0;
    periph_gnt = 1'b0; periph_r_valid = 1'b0;
    periph_r_rdata = '0; periph_r_opc = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    #2;
    total++;
    if ({gnt, r_valid, r_opc, tcdm_req, periph_req} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {gnt, r_valid, r_opc, tcdm_req, periph_req});
    end
    total++;
    if (r_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", r_rdata);
    end
    total++;
    if (dut.cnt !== 3'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tcdm_read();
    req = 1'b1; add = 32'h1000_0010; wen = 1'b1;
    be = 4'h3; wdata = 32'h5555_AAAA; tcdm_gnt = 1'b1;
    #2;
    total++;
    if ({gnt, tcdm_req, periph_req} !== 3'b110) begin
      bad++; $display("FAIL tcdm_gnt: got %b want 110",
                      {gnt, tcdm_req, periph_req});
    end
    total++;
    if ({o_add, o_wen, o_wdata, o_be}
        !== {32'h1000_0010, 1'b1, 32'h5555_AAAA, 4'h3}) begin
      bad++; $display("FAIL broadcast: got %h %b %h %h want 10000010 1 5555aaaa 3",
                      o_add, o_wen, o_wdata, o_be);
    end
    tick();
    req = 1'b0; tcdm_r_valid = 1'b1; tcdm_r_rdata = 32'hCAFE_0001;
    #2;
    total++;
    if ({r_valid, r_opc, r_rdata} !== {2'b10, 32'hCAFE_0001}) begin
      bad++; $display("FAIL tcdm_resp: got %b%b %h want 10 cafe0001",
                      r_valid, r_opc, r_rdata);
    end
    tick();
    tcdm_r_valid = 1'b0;
    #2;
    total++;
    if (dut.cnt !== 3'd0) begin
      bad++; $display("FAIL tcdm_cnt: got %0d want 0", dut.cnt);
    end
  endtask

  task automatic test_outstanding();
    tcdm_gnt = 1'b1; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add = 32'h1000_0100 + 32'(4 * i);
      #2;
      total++;
      if (gnt !== 1'b1) begin
        bad++; $display("FAIL out_gnt%0d: got %b want 1", i, gnt);
      end
      tick();
    end
    add = 32'h1000_0200;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++;
      if ({gnt, tcdm_req} !== 2'b00) begin
        bad++; $display("FAIL out_full%0d: got %b want 00", i, {gnt, tcdm_req});
      end
      tick();
    end
    tcdm_r_valid = 1'b1; tcdm_r_rdata = 32'h0000_0100;
    #2;
    total++;
    if ({r_valid, gnt} !== 2'b10) begin
      bad++; $display("FAIL out_ret: got %b want 10", {r_valid, gnt});
    end
    tick();
    tcdm_r_valid = 1'b0;
    #2;
    total++;
    if (gnt !== 1'b1) begin
      bad++; $display("FAIL out_5th: got %b want 1", gnt);
    end
    tick();
    req = 1'b0; tcdm_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tcdm_r_rdata = 32'(i);
      #2;
      total++;
      if ({r_valid, r_rdata} !== {1'b1, 32'(i)}) begin
        bad++; $display("FAIL out_drain%0d: got %b %h want 1 %h",
                        i, r_valid, r_rdata, 32'(i));
      end
      tick();
    end
    tcdm_r_valid = 1'b0;
    #2;
    total++;
    if (dut.cnt !== 3'd0) begin
      bad++; $display("FAIL out_cnt: got %0d want 0", dut.cnt);
    end
  endtask

  task automatic test_order();
    req = 1'b1; add = 32'h1000_0020; wen = 1'b1; tcdm_gnt = 1'b1;
    #2;
    total++;
    if (gnt !== 1'b1) begin
      bad++; $display("FAIL ord_tgnt: got %b want 1", gnt);
    end
    tick();
    add = 32'h1020_0004; wen = 1'b0; wdata = 32'hA5A5_0004;
    periph_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++;
      if ({periph_req, gnt} !== 2'b00) begin
        bad++; $display("FAIL ord_stall%0d: got %b want 00", i, {periph_req, gnt});
      end
      tick();
    end
    tcdm_r_valid = 1'b1; tcdm_r_rdata = 32'h0000_0020;
    #2;
    total++;
    if ({periph_req, r_valid} !== 2'b01) begin
      bad++; $display("FAIL ord_tresp: got %b want 01", {periph_req, r_valid});
    end
    tick();
    tcdm_r_valid = 1'b0;
    #2;
    total++;
    if ({periph_req, gnt, tcdm_req} !== 3'b110) begin
      bad++; $display("FAIL ord_pgnt: got %b want 110",
                      {periph_req, gnt, tcdm_req});
    end
    tick();
    req = 1'b0; periph_gnt = 1'b0;
    periph_r_valid = 1'b1; periph_r_opc = 1'b1;
    periph_r_rdata = 32'h0BAD_F00D;
    #2;
    total++;
    if ({r_valid, r_opc, r_rdata} !== {2'b11, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL ord_presp: got %b%b %h want 11 0badf00d",
                      r_valid, r_opc, r_rdata);
    end
    tick();
    periph_r_valid = 1'b0; periph_r_opc = 1'b0;
    #2;
    total++;
    if (dut.cnt !== 3'd0) begin
      bad++; $display("FAIL ord_cnt: got %0d want 0", dut.cnt);
    end
  endtask

  task automatic test_err();
    req = 1'b1; add = 32'h0000_0000; wen = 1'b1;
    tcdm_gnt = 1'b1; periph_gnt = 1'b1;
    #2;
    total++;
    if ({gnt, tcdm_req, periph_req} !== 3'b100) begin
      bad++; $display("FAIL err_gnt: got %b want 100",
                      {gnt, tcdm_req, periph_req});
    end
    tick();
    add = 32'hFFFF_FFFC;
    #2;
    total++;
    if ({r_valid, r_opc, r_rdata, gnt, tcdm_req, periph_req}
        !== {2'b11, 32'hBADA_CCE5, 3'b100}) begin
      bad++; $display("FAIL err_resp1: got %b%b %h %b want 11 badacce5 100",
                      r_valid, r_opc, r_rdata, {gnt, tcdm_req, periph_req});
    end
    tick();
    req = 1'b0;
    #2;
    total++;
    if ({r_valid, r_opc, r_rdata} !== {2'b11, 32'hBADA_CCE5}) begin
      bad++; $display("FAIL err_resp2: got %b%b %h want 11 badacce5",
                      r_valid, r_opc, r_rdata);
    end
    tick();
    #2;
    total++;
    if ({r_valid, dut.cnt} !== {1'b0, 3'd0}) begin
      bad++; $display("FAIL err_idle: got %b %0d want 0 0", r_valid, dut.cnt);
    end
    tcdm_gnt = 1'b0; periph_gnt = 1'b0; req = 1'b1;
    add = 32'h1001_FFFC;
    #2;
    total++;
    if ({tcdm_req, periph_req, gnt} !== 3'b100) begin
      bad++; $display("FAIL bnd_tlast: got %b want 100",
                      {tcdm_req, periph_req, gnt});
    end
    add = 32'h1020_3FFC;
    #2;
    total++;
    if ({tcdm_req, periph_req, gnt} !== 3'b010) begin
      bad++; $display("FAIL bnd_plast: got %b want 010",
                      {tcdm_req, periph_req, gnt});
    end
    add = 32'h1002_0000;
    #2;
    total++;
    if ({tcdm_req, periph_req, gnt} !== 3'b001) begin
      bad++; $display("FAIL bnd_tend: got %b want 001",
                      {tcdm_req, periph_req, gnt});
    end
    tick();
    add = 32'h1020_4000;
    #2;
    total++;
    if ({tcdm_req, periph_req, gnt, r_valid, r_opc} !== 5'b00111) begin
      bad++; $display("FAIL bnd_pend: got %b want 00111",
                      {tcdm_req, periph_req, gnt, r_valid, r_opc});
    end
    tick();
    req = 1'b0;
    #2;
    total++;
    if ({r_valid, r_opc} !== 2'b11) begin
      bad++; $display("FAIL bnd_resp: got %b want 11", {r_valid, r_opc});
    end
    tick();
  endtask

  task automatic test_same_cycle();
    req = 1'b1; add = 32'h1000_0040; tcdm_gnt = 1'b1;
    tick(); tick();
    #2;
    total++;
    if (dut.cnt !== 3'd2) begin
      bad++; $display("FAIL sc_fill: got %0d want 2", dut.cnt);
    end
    tcdm_r_valid = 1'b1; tcdm_r_rdata = 32'h0000_0040;
    #1;
    total++;
    if ({gnt, r_valid} !== 2'b11) begin
      bad++; $display("FAIL sc_both: got %b want 11", {gnt, r_valid});
    end
    tick();
    req = 1'b0; tcdm_r_valid = 1'b0;
    periph_r_valid = 1'b1; periph_r_rdata = 32'h7777_7777;
    #2;
    total++;
    if ({dut.cnt, r_valid} !== {3'd2, 1'b0}) begin
      bad++; $display("FAIL sc_stray: got %0d %b want 2 0", dut.cnt, r_valid);
    end
    tick();
    periph_r_valid = 1'b0;
    #2;
    total++;
    if (dut.cnt !== 3'd2) begin
      bad++; $display("FAIL sc_hold: got %0d want 2", dut.cnt);
    end
    tcdm_r_valid = 1'b1;
    tick(); tick();
    tcdm_r_valid = 1'b0;
    #2;
    total++;
    if (dut.cnt !== 3'd0) begin
      bad++; $display("FAIL sc_drain: got %0d want 0", dut.cnt);
    end
  endtask

  task automatic test_reset_mid();
    req = 1'b1; add = 32'h1000_0080; tcdm_gnt = 1'b1;
    tick(); tick(); tick();
    #1;
    total++;
    if (dut.cnt !== 3'd3) begin
      bad++; $display("FAIL rm_fill: got %0d want 3", dut.cnt);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({dut.cnt, gnt, tcdm_req, periph_req, r_valid, r_opc}
        !== {3'd0, 5'b0}) begin
      bad++; $display("FAIL rm_async: got %0d %b want 0 00000", dut.cnt,
                      {gnt, tcdm_req, periph_req, r_valid, r_opc});
    end
    tick(); tick();
    rst = 1'b0; req = 1'b0;
    tick();
    tcdm_r_valid = 1'b1; tcdm_r_rdata = 32'h0000_1234;
    #2;
    total++;
    if ({r_valid, r_rdata} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL rm_late: got %b %h want 0 0", r_valid, r_rdata);
    end
    tick();
    tcdm_r_valid = 1'b0; req = 1'b1;
    #2;
    total++;
    if ({dut.cnt, gnt, tcdm_req} !== {3'd0, 2'b11}) begin
      bad++; $display("FAIL rm_recover: got %0d %b want 0 11",
                      dut.cnt, {gnt, tcdm_req});
    end
    tick();
    req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tcdm_read();
    test_outstanding();
    test_order();
    test_err();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
